// File: rtl/dc_fetch_queue.sv
// -----------------------------------------------------------------------------
// dc_fetch_queue
//   Decode-side receiver of the IF->DC fetch handshake. Beats {pc, inst, jump}
//   are accepted on IF_valid && DC_ready and held in a DEPTH-entry in-order
//   FIFO. The FIFO head is offered to the decoder over a valid/ready port. A
//   back-end mispredict empties the queue in one cycle.
//
//   Optional feature, macro FQ_PREDECODE_EN: JAL beats that the branch
//   predictor did not mark taken raise a same-cycle early redirect
//   (DC_mispredict / DC_redirect_pc) back to fetch and are stored with
//   jump=1. When the macro is undefined both redirect outputs are tied to 0.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   IF_valid, IF_out_pc,
//   IF_out_inst, IF_out_jump  incoming fetch beat
//   DC_ready                  queue has space (registered state only)
//   mispredict                back-end flush, highest priority
//   DC_mispredict,
//   DC_redirect_pc            early JAL redirect to fetch
//   dec_valid, dec_ready,
//   dec_pc, dec_inst, dec_jump  head entry to decoder
//   fq_count                  current occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module dc_fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         IF_valid,
    input  logic [31:0]                  IF_out_pc,
    input  logic [31:0]                  IF_out_inst,
    input  logic                         IF_out_jump,
    output logic                         DC_ready,
    input  logic                         mispredict,
    output logic                         DC_mispredict,
    output logic [31:0]                  DC_redirect_pc,
    output logic                         dec_valid,
    input  logic                         dec_ready,
    output logic [31:0]                  dec_pc,
    output logic [31:0]                  dec_inst,
    output logic                         dec_jump,
    output logic [$clog2(DEPTH):0]       fq_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

`ifdef FQ_PREDECODE_EN
    // J-type immediate of a JAL instruction, sign-extended to 32 bits.
    function automatic logic [31:0] jal_imm(input logic [31:0] i);
        return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
    endfunction
`endif

    logic [31:0]      pc_mem_q   [DEPTH];
    logic [31:0]      inst_mem_q [DEPTH];
    logic             jump_mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;

    logic             enq_fire;
    logic             deq_fire;
    logic             jal_redirect;
    logic             store_jump;

    // Handshake qualification; mispredict suppresses both sides.
    always_comb begin
        DC_ready  = (count_q < FULL_CNT);
        dec_valid = (count_q != {(PTR_W + 1){1'b0}});
        enq_fire  = IF_valid && DC_ready && !mispredict;
        deq_fire  = dec_valid && dec_ready && !mispredict;
    end

    // Early JAL redirect; only beats actually enqueued can redirect.
    always_comb begin
        jal_redirect   = 1'b0;
        DC_redirect_pc = 32'h0000_0000;
`ifdef FQ_PREDECODE_EN
        if (enq_fire && (IF_out_inst[6:0] == 7'b1101111) && !IF_out_jump) begin
            jal_redirect   = 1'b1;
            DC_redirect_pc = IF_out_pc + jal_imm(IF_out_inst);
        end else begin
            jal_redirect   = 1'b0;
            DC_redirect_pc = 32'h0000_0000;
        end
`endif
        DC_mispredict = jal_redirect;
        store_jump    = IF_out_jump | jal_redirect;
    end

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (mispredict) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {(PTR_W + 1){1'b0}};
        end else begin
            if (enq_fire) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (deq_fire) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W + 1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            pc_mem_q[wr_ptr_q]   <= IF_out_pc;
            inst_mem_q[wr_ptr_q] <= IF_out_inst;
            jump_mem_q[wr_ptr_q] <= store_jump;
        end
    end

    // Head presentation; zeroed while empty so stale entries never leak out.
    always_comb begin
        fq_count = count_q;
        if (dec_valid) begin
            dec_pc   = pc_mem_q[rd_ptr_q];
            dec_inst = inst_mem_q[rd_ptr_q];
            dec_jump = jump_mem_q[rd_ptr_q];
        end else begin
            dec_pc   = 32'h0000_0000;
            dec_inst = 32'h0000_0000;
            dec_jump = 1'b0;
        end
    end

    // Occupancy invariants: never write when full, never read when empty.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(enq_fire && (count_q == FULL_CNT)));
            assert (!(deq_fire && (count_q == {(PTR_W + 1){1'b0}})));
        end
    end

endmodule

// File: tb/tb_dc_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_dc_fetch_queue
//   Directed bench for dc_fetch_queue (DEPTH=4). Every expected value below is
//   hand-computed from the intended queue behaviour.
// -----------------------------------------------------------------------------
module tb_dc_fetch_queue;

    logic        clk;
    logic        rst;
    logic        IF_valid;
    logic [31:0] IF_out_pc;
    logic [31:0] IF_out_inst;
    logic        IF_out_jump;
    logic        DC_ready;
    logic        mispredict;
    logic        DC_mispredict;
    logic [31:0] DC_redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_pc;
    logic [31:0] dec_inst;
    logic        dec_jump;
    logic [2:0]  fq_count;

    int checks_cnt;
    int errors_cnt;

    dc_fetch_queue #(.DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .IF_valid       (IF_valid),
        .IF_out_pc      (IF_out_pc),
        .IF_out_inst    (IF_out_inst),
        .IF_out_jump    (IF_out_jump),
        .DC_ready       (DC_ready),
        .mispredict     (mispredict),
        .DC_mispredict  (DC_mispredict),
        .DC_redirect_pc (DC_redirect_pc),
        .dec_valid      (dec_valid),
        .dec_ready      (dec_ready),
        .dec_pc         (dec_pc),
        .dec_inst       (dec_inst),
        .dec_jump       (dec_jump),
        .fq_count       (fq_count)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point for the whole bench.
    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock, sample point is 1 unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic v, input logic [31:0] pc,
                              input logic [31:0] inst, input logic jmp);
        IF_valid    = v;
        IF_out_pc   = pc;
        IF_out_inst = inst;
        IF_out_jump = jmp;
    endtask

    // Empty the queue with a bounded number of cycles.
    task automatic drain();
        dec_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (fq_count != 3'd0) tick();
        end
        dec_ready = 1'b0;
        check_val("drain_empty", {29'd0, fq_count}, 32'd0);
    endtask

    initial begin
        checks_cnt = 0;
        errors_cnt = 0;
        rst        = 1'b1;
        mispredict = 1'b0;
        dec_ready  = 1'b0;
        drive_beat(1'b0, 32'h0, 32'h0, 1'b0);
        tick();
        tick();

        // Reset state
        check_val("rst_dec_valid", {31'd0, dec_valid}, 32'd0);
        check_val("rst_dc_ready", {31'd0, DC_ready}, 32'd1);
        check_val("rst_count", {29'd0, fq_count}, 32'd0);
        check_val("rst_dec_pc", dec_pc, 32'h0);
        check_val("rst_dc_misp", {31'd0, DC_mispredict}, 32'd0);
        check_val("rst_redir_pc", DC_redirect_pc, 32'h0);
        rst = 1'b0;

        // 1: single beat, no empty bypass, one-cycle latency
        drive_beat(1'b1, 32'h0000_2000, 32'h0000_0013, 1'b0);
        #1;
        check_val("t1_no_bypass", {31'd0, dec_valid}, 32'd0);
        check_val("t1_nonjal_misp", {31'd0, DC_mispredict}, 32'd0);
        tick();
        drive_beat(1'b0, 32'h0, 32'h0, 1'b0);
        check_val("t1_dec_valid", {31'd0, dec_valid}, 32'd1);
        check_val("t1_dec_pc", dec_pc, 32'h0000_2000);
        check_val("t1_dec_inst", dec_inst, 32'h0000_0013);
        check_val("t1_count", {29'd0, fq_count}, 32'd1);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        check_val("t1_count_after", {29'd0, fq_count}, 32'd0);
        check_val("t1_valid_after", {31'd0, dec_valid}, 32'd0);

        // 2: fill to DEPTH, fifth beat refused, order preserved
        for (int i = 0; i < 5; i++) begin
            drive_beat(1'b1, 32'h0000_2000 + 32'(4 * i), 32'h0000_0013, 1'b0);
            if (i == 4) check_val("t2_full_ready", {31'd0, DC_ready}, 32'd0);
            tick();
        end
        drive_beat(1'b0, 32'h0, 32'h0, 1'b0);
        check_val("t2_count_full", {29'd0, fq_count}, 32'd4);
        check_val("t2_head", dec_pc, 32'h0000_2000);
        dec_ready = 1'b1;
        tick();
        dec_ready = 1'b0;
        check_val("t2_ready_back", {31'd0, DC_ready}, 32'd1);
        check_val("t2_count3", {29'd0, fq_count}, 32'd3);
        dec_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            check_val("t2_order", dec_pc, 32'h0000_2000 + 32'(4 * k));
            tick();
        end
        dec_ready = 1'b0;
        check_val("t2_drained", {29'd0, fq_count}, 32'd0);

        // 3: full queue with enq+deq, pointer wrap
        for (int i = 0; i < 4; i++) begin
            drive_beat(1'b1, 32'h0000_4000 + 32'(4 * i), 32'h0000_0013, 1'b0);
            tick();
        end
        dec_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            drive_beat(1'b1, 32'h0000_4010 + 32'(4 * ((j == 0) ? 0 : j - 1)), 32'h0000_0013, 1'b0);
            check_val("t3_head", dec_pc, 32'h0000_4000 + 32'(4 * j));
            tick();
            check_val("t3_count", {29'd0, fq_count}, 32'd3);
        end
        drive_beat(1'b0, 32'h0, 32'h0, 1'b0);
        dec_ready = 1'b0;
        check_val("t3_head_final", dec_pc, 32'h0000_4014);

        // 4: mispredict flushes 3 queued beats, drops the incoming one
        drive_beat(1'b1, 32'h0000_5000, 32'h0000_0013, 1'b0);
        mispredict = 1'b1;
        dec_ready  = 1'b1;
        tick();
        mispredict = 1'b0;
        dec_ready  = 1'b0;
        drive_beat(1'b1, 32'h0000_3000, 32'h0000_0013, 1'b0);
        check_val("t4_count0", {29'd0, fq_count}, 32'd0);
        check_val("t4_valid0", {31'd0, dec_valid}, 32'd0);
        check_val("t4_ready", {31'd0, DC_ready}, 32'd1);
        tick();
        drive_beat(1'b0, 32'h0, 32'h0, 1'b0);
        check_val("t4_valid1", {31'd0, dec_valid}, 32'd1);
        check_val("t4_pc", dec_pc, 32'h0000_3000);
        check_val("t4_count1", {29'd0, fq_count}, 32'd1);
        drain();

        // 5: JAL predecode (or pass-through when the feature is off)
        drive_beat(1'b1, 32'h0000_2010, 32'h0100_006F, 1'b0);
        #1;
`ifdef FQ_PREDECODE_EN
        check_val("t5_misp", {31'd0, DC_mispredict}, 32'd1);
        check_val("t5_target", DC_redirect_pc, 32'h0000_2020);
`else
        check_val("t5_misp_off", {31'd0, DC_mispredict}, 32'd0);
        check_val("t5_target_off", DC_redirect_pc, 32'h0);
`endif
        tick();
        drive_beat(1'b0, 32'h0, 32'h0, 1'b0);
        check_val("t5_misp_clr", {31'd0, DC_mispredict}, 32'd0);
        check_val("t5_redir_clr", DC_redirect_pc, 32'h0);
        check_val("t5_dec_pc", dec_pc, 32'h0000_2010);
`ifdef FQ_PREDECODE_EN
        check_val("t5_jump_set", {31'd0, dec_jump}, 32'd1);
`else
        check_val("t5_jump_raw", {31'd0, dec_jump}, 32'd0);
`endif
        drain();
        drive_beat(1'b1, 32'h0000_2010, 32'h0100_006F, 1'b1);
        #1;
        check_val("t5_pred_nomisp", {31'd0, DC_mispredict}, 32'd0);
        tick();
        drive_beat(1'b0, 32'h0, 32'h0, 1'b0);
        check_val("t5_pred_jump", {31'd0, dec_jump}, 32'd1);
        drain();

        // 6: JAL coinciding with mispredict is dropped, no redirect
        drive_beat(1'b1, 32'h0000_2010, 32'h0100_006F, 1'b0);
        mispredict = 1'b1;
        #1;
        check_val("t6_misp_blocked", {31'd0, DC_mispredict}, 32'd0);
        tick();
        mispredict = 1'b0;
        drive_beat(1'b0, 32'h0, 32'h0, 1'b0);
        check_val("t6_dropped", {29'd0, fq_count}, 32'd0);

        // Mid-operation reset loses queued beats
        drive_beat(1'b1, 32'h0000_6000, 32'h0000_0013, 1'b0);
        tick();
        tick();
        drive_beat(1'b0, 32'h0, 32'h0, 1'b0);
        check_val("rst2_pre", {29'd0, fq_count}, 32'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("rst2_count", {29'd0, fq_count}, 32'd0);
        check_val("rst2_valid", {31'd0, dec_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors_cnt, checks_cnt);
        $finish;
    end

endmodule
